// File: rtl/adder_axil_slave.sv
// AXI4-Lite adder peripheral (OP_A/OP_B RW, SUM/STATUS RO). The sum lands 1 cycle after an operand commit; reads take 1 cycle.
// No AW/W is accepted while bvalid waits for bready, and no AR while rvalid waits for rready. Optional macro: RO_SLVERR_EN.
module adder_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready
);

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;

  wstate_t     wstate, wstate_nxt;
  logic        ready_en;
  logic [1:0]  aw_sel_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        commit;
  logic [1:0]  cm_sel;
  logic [31:0] cm_data;
  logic [3:0]  cm_strb;
  logic [1:0]  cm_resp;
  logic [1:0]  bresp_q;

  logic [31:0] op_a, op_b, sum;
  logic        carry, sum_valid, sum_pend;
  logic [15:0] update_cnt;
  logic [31:0] rd_mux;

  logic unused;
  assign unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] din,
                                              input logic [3:0] strb);
    merge_bytes = old;
    for (int k = 0; k < 4; k++)
      if (strb[k]) merge_bytes[8*k +: 8] = din[8*k +: 8];
  endfunction

  // Ready lines stay low through reset and for the edge that releases it.
  always_ff @(posedge ACLK) begin
    if (ARESET) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) wstate <= W_IDLE;
    else        wstate <= wstate_nxt;
  end

  always_comb begin
    wstate_nxt      = wstate;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;
    commit          = 1'b0;
    case (wstate)
      W_IDLE: begin
        s00_axi_awready = ready_en;
        s00_axi_wready  = ready_en;
        if (ready_en && s00_axi_awvalid && s00_axi_wvalid) begin
          wstate_nxt = W_RESP;
          commit     = 1'b1;
        end else if (ready_en && s00_axi_awvalid) begin
          wstate_nxt = W_HAVE_AW;
        end else if (ready_en && s00_axi_wvalid) begin
          wstate_nxt = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        s00_axi_wready = ready_en;
        if (ready_en && s00_axi_wvalid) begin
          wstate_nxt = W_RESP;
          commit     = 1'b1;
        end
      end
      W_HAVE_W: begin
        s00_axi_awready = ready_en;
        if (ready_en && s00_axi_awvalid) begin
          wstate_nxt = W_RESP;
          commit     = 1'b1;
        end
      end
      W_RESP: begin
        s00_axi_bvalid = 1'b1;
        if (s00_axi_bready) wstate_nxt = W_IDLE;
      end
    endcase
  end

  // The half of the pair arriving on the commit edge comes straight from the bus.
  assign cm_sel  = (wstate == W_HAVE_AW) ? aw_sel_q : s00_axi_awaddr[3:2];
  assign cm_data = (wstate == W_HAVE_W)  ? wdata_q  : s00_axi_wdata[31:0];
  assign cm_strb = (wstate == W_HAVE_W)  ? wstrb_q  : s00_axi_wstrb[3:0];

`ifdef RO_SLVERR_EN
  assign cm_resp = cm_sel[1] ? 2'b10 : 2'b00;
`else
  assign cm_resp = 2'b00;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_sel_q <= 2'b00;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= 2'b00;
    end else begin
      if (s00_axi_awvalid && s00_axi_awready) aw_sel_q <= s00_axi_awaddr[3:2];
      if (s00_axi_wvalid && s00_axi_wready) begin
        wdata_q <= s00_axi_wdata[31:0];
        wstrb_q <= s00_axi_wstrb[3:0];
      end
      if (commit) bresp_q <= cm_resp;
    end
  end
  assign s00_axi_bresp = bresp_q;

  // The adder runs one edge after a commit, so it always sees the updated operands.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      op_a       <= '0;
      op_b       <= '0;
      sum        <= '0;
      carry      <= 1'b0;
      sum_valid  <= 1'b0;
      sum_pend   <= 1'b0;
      update_cnt <= '0;
    end else begin
      sum_pend <= 1'b0;
      if (sum_pend) begin
        {carry, sum} <= {1'b0, op_a} + {1'b0, op_b};
        sum_valid    <= 1'b1;
        update_cnt   <= update_cnt + 16'd1;
      end
      if (commit && !cm_sel[1]) begin
        if (cm_sel[0]) op_b <= merge_bytes(op_b, cm_data, cm_strb);
        else           op_a <= merge_bytes(op_a, cm_data, cm_strb);
        sum_valid <= 1'b0;
        sum_pend  <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (s00_axi_araddr[3:2])
      2'd0: rd_mux = op_a;
      2'd1: rd_mux = op_b;
      2'd2: rd_mux = sum;
      2'd3: rd_mux = {update_cnt, 14'd0, sum_valid, carry};
    endcase
  end

  assign s00_axi_arready = ready_en && !s00_axi_rvalid;
  assign s00_axi_rresp   = 2'b00;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata  <= '0;
    end else if (s00_axi_arvalid && s00_axi_arready) begin
      s00_axi_rvalid <= 1'b1;
      s00_axi_rdata  <= rd_mux;
    end else if (s00_axi_rready) begin
      s00_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_axil_slave.sv
// Directed plus randomized bench for adder_axil_slave, checked against a register-level model.
module tb_adder_axil_slave;

  logic        ACLK, ARESET;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int errors = 0;
  int checks = 0;

`ifdef RO_SLVERR_EN
  localparam logic [1:0] RO_RESP = 2'b10;
`else
  localparam logic [1:0] RO_RESP = 2'b00;
`endif

  adder_axil_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Register-level model of the peripheral.
  logic [31:0] m_reg [0:1];
  logic [31:0] m_sum;
  logic        m_carry, m_valid;
  logic [15:0] m_cnt;

  task automatic m_reset();
    m_reg[0] = '0; m_reg[1] = '0; m_sum = '0; m_carry = 1'b0; m_valid = 1'b0; m_cnt = '0;
  endtask

  task automatic m_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [32:0] t;
    if (a[3]) return;
    for (int k = 0; k < 4; k++)
      if (s[k]) m_reg[a[2]][8*k +: 8] = d[8*k +: 8];
    t = {1'b0, m_reg[0]} + {1'b0, m_reg[1]};
    m_sum = t[31:0]; m_carry = t[32]; m_valid = 1'b1; m_cnt = m_cnt + 16'd1;
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    m_read = m_reg[0];
      2'd1:    m_read = m_reg[1];
      2'd2:    m_read = m_sum;
      default: m_read = {m_cnt, 14'd0, m_valid, m_carry};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK); #1;
  endtask

  task automatic send_aw_w(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_done, w_done, aw_fire, w_fire;
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      step();
      if (aw_fire) begin awvalid = 1'b0; aw_done = 1; end
      if (w_fire)  begin wvalid = 1'b0;  w_done = 1;  end
      n++;
    end
    if (!(aw_done && w_done)) check("aw_w_timeout", 32'd0, 32'd1);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic get_b(output logic [1:0] resp);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 50) begin step(); n++; end
    if (!bvalid) check("b_timeout", 32'd0, 32'd1);
    resp = bresp;
    step();
    bready = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    send_aw_w(a, d, s);
    get_b(resp);
    m_write(a, d, s);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 50) begin step(); n++; end
    if (!arready) check("ar_timeout", 32'd0, 32'd1);
    step();
    arvalid = 1'b0;
    check("r_latency", rvalid, 1'b1);
    d = rdata;
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [3:0] a);
    logic [31:0] d;
    axi_read(a, d);
    check(tag, d, m_read(a));
  endtask

  // Write with AW+W together and an AR on the commit edge (dly=0) or the edge after (dly=1).
  task automatic overlap(input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                         input logic [3:0] ra, input int dly, output logic [31:0] rd);
    check("ov_ready", {awready, wready, arready}, 3'b111);
    awaddr = wa; wdata = wd; wstrb = ws; awvalid = 1'b1; wvalid = 1'b1;
    if (dly == 0) begin araddr = ra; arvalid = 1'b1; end
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("ov_bvalid", bvalid, 1'b1);
    if (dly == 1) begin
      araddr = ra; arvalid = 1'b1;
      check("ov_arready", arready, 1'b1);
      step();
    end
    arvalid = 1'b0;
    check("ov_rvalid", rvalid, 1'b1);
    rd = rdata;
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    check("ov_done", {bvalid, rvalid}, 2'b00);
    m_write(wa, wd, ws);
  endtask

  // One half of the write pair leads the other by gap cycles; the skid copy must be used.
  task automatic skew(input bit aw_first, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int gap);
    logic [1:0] r;
    if (aw_first) begin
      awaddr = a; awvalid = 1'b1;
      check("skew_first_rdy", awready, 1'b1);
      step();
      awvalid = 1'b0; awaddr = a ^ 4'h4;
    end else begin
      wdata = d; wstrb = s; wvalid = 1'b1;
      check("skew_first_rdy", wready, 1'b1);
      step();
      wvalid = 1'b0; wdata = ~d; wstrb = ~s;
    end
    for (int i = 0; i < gap; i++) begin
      check("skew_hold", {bvalid, aw_first ? awready : wready}, 2'b00);
      step();
    end
    if (aw_first) begin
      wdata = d; wstrb = s; wvalid = 1'b1;
      check("skew_second_rdy", wready, 1'b1);
    end else begin
      awaddr = a; awvalid = 1'b1;
      check("skew_second_rdy", awready, 1'b1);
    end
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("skew_bvalid", bvalid, 1'b1);
    get_b(r);
    check("skew_bresp", r, 2'b00);
    m_write(a, d, s);
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] d, exp_v;

    ARESET = 1'b1; awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arprot = '0; arvalid = 0; rready = 0;
    m_reset();
    repeat (3) step();
    check("reset_ctrl", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, 0);
    check("reset_rdata", rdata, 32'd0);
    ARESET = 1'b0;
    check("ready_before_edge", {awready, wready, arready}, 3'b000);
    step();
    check("ready_after_edge", {awready, wready, arready}, 3'b111);

    // Basic add
    axi_write(4'h0, 32'h1, 4'hF, r); check("t1_bresp_a", r, 2'b00);
    axi_write(4'h4, 32'h2, 4'hF, r); check("t1_bresp_b", r, 2'b00);
    axi_read(4'h8, d); check("t1_sum", d, 32'h00000003);
    axi_read(4'hC, d); check("t1_status", d, 32'h00020002);

    // Carry out
    axi_write(4'h0, 32'hFFFFFFFF, 4'hF, r);
    axi_write(4'h4, 32'h00000002, 4'hF, r);
    axi_read(4'h8, d); check("t2_sum", d, 32'h00000001);
    axi_read(4'hC, d); check("t2_status_bits", d[1:0], 2'b11);
    check_rd("t2_status_model", 4'hC);

    // Byte strobes, stale reads around the commit edge
    axi_write(4'h0, 32'h11223344, 4'hF, r);
    exp_v = m_read(4'h8);
    overlap(4'h0, 32'hAABBCCDD, 4'b0001, 4'h8, 1, d);
    check("t3_stale_sum", d, exp_v);
    axi_read(4'h0, d); check("t3_op_a", d, 32'h112233DD);
    check_rd("t3_new_sum", 4'h8);
    exp_v = m_read(4'hC) & 32'hFFFF_FFFD;
    overlap(4'h4, 32'h00000100, 4'hF, 4'hC, 1, d);
    check("t3_status_invalid", d, exp_v);
    exp_v = m_read(4'h0);
    overlap(4'h0, 32'h55667788, 4'hF, 4'h0, 0, d);
    check("t3_pre_commit", d, exp_v);
    check_rd("t3_status", 4'hC);

    // Skewed AW/W arrival
    skew(1'b0, 4'h4, 32'h0000_1000, 4'hF, 3);
    check_rd("t4_w_first_status", 4'hC);
    skew(1'b1, 4'h0, 32'h0000_2000, 4'hF, 3);
    check_rd("t4_aw_first_status", 4'hC);
    check_rd("t4_sum", 4'h8);

    // B backpressure, then R backpressure
    send_aw_w(4'h0, 32'h0000_0007, 4'hF);
    m_write(4'h0, 32'h0000_0007, 4'hF);
    awaddr = 4'h4; wdata = 32'h0000_0009; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t5_b_stall", {bvalid, awready, wready}, 3'b100);
      step();
    end
    get_b(r); check("t5_bresp", r, 2'b00);
    axi_write(4'h4, 32'h0000_0009, 4'hF, r);
    check_rd("t5_sum", 4'h8);
    araddr = 4'h8; arvalid = 1'b1;
    step();
    araddr = 4'hC;
    for (int i = 0; i < 4; i++) begin
      check("t5_r_stall", {rvalid, arready}, 2'b10);
      check("t5_r_stable", rdata, m_read(4'h8));
      step();
    end
    rready = 1'b1; step(); rready = 1'b0;
    step();
    arvalid = 1'b0;
    check("t5_next_read", rdata, m_read(4'hC));
    rready = 1'b1; step(); rready = 1'b0;

    // Read-only targets
    axi_write(4'h8, 32'h0000DEAD, 4'hF, r); check("t6_bresp_sum", r, RO_RESP);
    axi_write(4'hC, 32'h0000BEEF, 4'hF, r); check("t6_bresp_status", r, RO_RESP);
    check_rd("t6_sum_unchanged", 4'h8);
    check_rd("t6_status_unchanged", 4'hC);

    // Randomized operand traffic
    for (int it = 0; it < 24; it++) begin
      logic [3:0]  a;
      logic [31:0] v;
      logic [3:0]  s;
      int mode;
      a = $urandom_range(0, 1) ? 4'h4 : 4'h0;
      v = $urandom;
      s = 4'($urandom_range(1, 15));
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        axi_write(a, v, s, r); check("rnd_bresp", r, 2'b00);
      end else begin
        skew(mode == 1, a, v, s, $urandom_range(1, 3));
      end
      check_rd("rnd_sum", 4'h8);
      check_rd("rnd_status", 4'hC);
      if (it % 4 == 0) check_rd("rnd_op", a);
    end

    // Reset with an AW held in the skid register
    awaddr = 4'h0; awvalid = 1'b1;
    check("t7_aw_rdy", awready, 1'b1);
    step();
    awvalid = 1'b0;
    ARESET = 1'b1;
    step();
    check("t7_reset_ctrl", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, 0);
    check("t7_reset_rdata", rdata, 32'd0);
    ARESET = 1'b0;
    m_reset();
    for (int i = 0; i < 5; i++) begin
      check("t7_no_bvalid", bvalid, 1'b0);
      step();
    end
    check_rd("t7_sum_cleared", 4'h8);
    check_rd("t7_status_cleared", 4'hC);
    check_rd("t7_op_a_cleared", 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
